// File: rtl/llr_bram_pair_reader_if.sv
// rtl/llr_bram_pair_reader_if.sv - LLR RAM read ports and decoder-side pair stream
interface llr_bram_pair_reader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
);
    logic                  ena;
    logic                  enb;
    logic [ADDR_W-1:0]     addra;
    logic [ADDR_W-1:0]     addrb;
    logic [DATA_W-1:0]     douta;
    logic [DATA_W-1:0]     doutb;
    logic                  m_valid;
    logic                  m_ready;
    logic [2*DATA_W-1:0]   m_data;
    logic                  m_last;

    modport master (
        output ena, enb, addra, addrb, m_valid, m_data, m_last,
        input  douta, doutb, m_ready
    );

    modport slave (
        input  ena, enb, addra, addrb, m_valid, m_data, m_last,
        output douta, doutb, m_ready
    );
endinterface

// File: rtl/llr_bram_pair_reader.sv
// rtl/llr_bram_pair_reader.sv - walks an LLR RAM range issuing paired even/odd reads
// and streams the pairs out through a 3-entry credit-protected FIFO.
module llr_bram_pair_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W-1:0]          num_pairs,
    output logic                       busy,
    output logic                       done,
    llr_bram_pair_reader_if.master     bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_W-1:0]    addr;
    logic [ADDR_W-1:0]    reads_left;
    logic                 inflight;
    logic                 inflight_last;
    logic [2*DATA_W:0]    fifo_mem [3];
    logic [1:0]           wr_ptr;
    logic [1:0]           rd_ptr;
    logic [1:0]           occ;
    logic                 issue;
    logic                 last_issue;
    logic                 push;
    logic                 pop;
    logic                 head_last;
    logic                 credit_ok;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued if its data is guaranteed a FIFO slot on arrival.
    assign credit_ok  = ({1'b0, occ} + {2'b00, inflight}) < 3'd3;
    assign last_issue = (reads_left == ADDR_W'(1));
    assign push       = inflight;
    assign pop        = bus.m_valid & bus.m_ready;
    assign head_last  = fifo_mem[rd_ptr][2*DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && (num_pairs != '0)) state_next = READ;
            READ:    if (issue && last_issue)        state_next = DRAIN;
            DRAIN:   if (pop && head_last)           state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        issue     = (state == READ) && credit_ok;
        bus.ena   = issue;
        bus.enb   = issue;
        bus.addra = addr;
        bus.addrb = {addr[ADDR_W-1:1], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= '0;
            reads_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && last_issue;
            done          <= ((state == IDLE) && start && (num_pairs == '0)) || (pop && head_last);
            if ((state == IDLE) && start) begin
                addr       <= base_addr & ~ADDR_W'(1);
                reads_left <= num_pairs;
            end else if (issue) begin
                addr       <= addr + ADDR_W'(2);
                reads_left <= reads_left - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {inflight_last, bus.doutb, bus.douta};
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign bus.m_valid              = (occ != 2'd0);
    assign {bus.m_last, bus.m_data} = fifo_mem[rd_ptr];
endmodule

// File: tb/tb_llr_bram_pair_reader.sv
// tb/tb_llr_bram_pair_reader.sv - scoreboard bench for llr_bram_pair_reader
module tb_llr_bram_pair_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] base_addr;
    logic [5:0] num_pairs;
    logic       busy;
    logic       done;
    logic       rdy_mode;
    logic [3:0] mem [64];

    int checks = 0;
    int errors = 0;
    int ahead = 0;
    int ena_cnt = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int pair_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_head = '0;

    logic [8:0] exp_q [$];
    logic [5:0] addr_q [$];

    always #5 clk = ~clk;

    llr_bram_pair_reader_if #(.ADDR_W(6), .DATA_W(4)) bus ();

    llr_bram_pair_reader #(.ADDR_W(6), .DATA_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_pairs (num_pairs),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always @(posedge clk) begin
        if (bus.ena) bus.douta <= mem[bus.addra];
        if (bus.enb) bus.doutb <= mem[bus.addrb];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ready pattern 1,0,0,1 repeating when rdy_mode is set.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                bus.m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ahead      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check_eq("head_stable", {bus.m_last, bus.m_data}, prev_head);
            if (bus.ena) begin
                logic [5:0] a;
                ahead++;
                ena_cnt++;
                check_eq("ahead_le3", ahead <= 3, 1);
                check_eq("enb_paired", bus.enb, 1);
                check_eq("read_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) begin
                    a = addr_q.pop_front();
                    check_eq("addra", bus.addra, a);
                    check_eq("addrb", bus.addrb, 6'(a + 6'd1));
                end
            end
            if (busy) busy_cnt++;
            if (bus.m_valid) valid_cnt++;
            if (done) done_cnt++;
            if (bus.m_valid && bus.m_ready) begin
                logic [8:0] e;
                ahead--;
                pair_cnt++;
                check_eq("pair_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("m_data", bus.m_data, e[7:0]);
                    check_eq("m_last", bus.m_last, e[8]);
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_head  = {bus.m_last, bus.m_data};
        end
    end

    // Leaves the caller at posedge+1 of cycle 1 (start was high in cycle 0).
    task automatic send_cmd(input logic [5:0] b, input logic [5:0] n);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        num_pairs = n;
        for (int i = 0; i < int'(n); i++) begin
            logic [5:0] a;
            a = (b & 6'h3E) + 6'(2 * i);
            addr_q.push_back(a);
            exp_q.push_back({(i == int'(n) - 1), mem[a | 6'd1], mem[a]});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_cnt, input int budget);
        int k = 0;
        while (done_cnt == base_cnt && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_timeout", done_cnt > base_cnt, 1);
    endtask

    initial begin
        int d0, p0, b0, e0, v0;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_pairs = '0;
        rdy_mode = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 4'(i);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ena", bus.ena, 0);
        check_eq("rst_enb", bus.enb, 0);
        check_eq("rst_addra", bus.addra, 0);
        check_eq("rst_addrb", bus.addrb, 1);
        check_eq("rst_valid", bus.m_valid, 0);
        check_eq("rst_data", bus.m_data, 0);
        check_eq("rst_last", bus.m_last, 0);
        rst_n = 1'b1;

        // Basic 4-pair read at full throughput, cycle-exact.
        bus.m_ready = 1'b1;
        p0 = pair_cnt;
        send_cmd(6'd0, 6'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("t1_busy_c%0d", c), busy, (c <= 6));
            check_eq($sformatf("t1_ena_c%0d", c), bus.ena, (c <= 4));
            check_eq($sformatf("t1_valid_c%0d", c), bus.m_valid, (c >= 3 && c <= 6));
            check_eq($sformatf("t1_last_c%0d", c), bus.m_last && bus.m_valid, (c == 6));
            check_eq($sformatf("t1_done_c%0d", c), done, (c == 7));
        end
        check_eq("t1_pairs", pair_cnt - p0, 4);

        // Same command with a stalling consumer.
        rdy_mode = 1'b1;
        d0 = done_cnt;
        p0 = pair_cnt;
        send_cmd(6'd0, 6'd4);
        wait_done(d0, 200);
        repeat (3) @(negedge clk);
        check_eq("t2_pairs", pair_cnt - p0, 4);
        check_eq("t2_q_empty", exp_q.size(), 0);
        rdy_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;

        // Address wrap at the top of the RAM.
        mem[62] = 4'hA;
        mem[63] = 4'hB;
        mem[0]  = 4'h1;
        mem[1]  = 4'h2;
        d0 = done_cnt;
        send_cmd(6'd62, 6'd2);
        wait_done(d0, 50);
        check_eq("t3_addr_q_empty", addr_q.size(), 0);
        check_eq("t3_q_empty", exp_q.size(), 0);

        // Zero-length command.
        d0 = done_cnt;
        b0 = busy_cnt;
        e0 = ena_cnt;
        v0 = valid_cnt;
        send_cmd(6'd5, 6'd0);
        @(negedge clk);
        check_eq("t4_done_next", done, 1);
        repeat (5) @(negedge clk);
        check_eq("t4_busy_never", busy_cnt - b0, 0);
        check_eq("t4_ena_never", ena_cnt - e0, 0);
        check_eq("t4_valid_never", valid_cnt - v0, 0);
        check_eq("t4_one_done", done_cnt - d0, 1);

        // Second start while busy is ignored.
        d0 = done_cnt;
        p0 = pair_cnt;
        send_cmd(6'd0, 6'd3);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 6'd10;
        num_pairs = 6'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0, 50);
        repeat (10) @(negedge clk);
        check_eq("t5_one_done", done_cnt - d0, 1);
        check_eq("t5_pairs", pair_cnt - p0, 3);
        check_eq("t5_addr_q_empty", addr_q.size(), 0);

        // Reset with two pairs buffered and one read in flight.
        bus.m_ready = 1'b0;
        d0 = done_cnt;
        send_cmd(6'd0, 6'd4);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6_pre_valid", bus.m_valid, 1);
        check_eq("t6_pre_ena", bus.ena, 0);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", bus.m_valid, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_ena", bus.ena, 0);
        check_eq("t6_rst_done", done, 0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        check_eq("t6_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        send_cmd(6'd8, 6'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_eq($sformatf("t6_done_c%0d", c), done, (c == 4));
        end
        check_eq("t6_one_done", done_cnt - d0, 1);
        check_eq("t6_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
